sc_sng: RTL and testbench



---
 rtl/sc_pkg.sv | 32 +++
 rtl/sc_lfsr.sv | 32 +++
 rtl/sc_sng.sv | 98 +++++++++
 tb/tb_sc_sng.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing blocks.
package sc_pkg;

    typedef enum logic {
        SNG_IDLE = 1'b0,
        SNG_RUN  = 1'b1
    } sng_state_t;

    // Right-shift Galois masks for maximal-length sequences, n = 4..16.
    function automatic logic [15:0] lfsr_taps(input int n);
        logic [15:0] m;
        m = '0;
        case (n)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0E08;
            13:      m = 16'h1C80;
            14:      m = 16'h3802;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Galois right-shift maximal-length LFSR; load (to SEED) has priority over en.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int              N    = 8,
    parameter logic [N-1:0]    SEED = N'(1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    output logic [N-1:0] q
);

    localparam logic [15:0]  TAPS16 = lfsr_taps(N);
    localparam logic [N-1:0] TAPS   = TAPS16[N-1:0];

    logic [N-1:0] r_lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else if (load) begin
            r_lfsr <= SEED;
        end else if (en) begin
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
        end
    end

    assign q = r_lfsr;

endmodule

// File: rtl/sc_sng.sv
// Stochastic number generator: N-bit value -> LEN-bit stochastic stream.
// Optional downstream stall via the SC_SNG_STALL_EN macro (adds the hold port).
module sc_sng
    import sc_pkg::*;
#(
    parameter int          N    = 8,
    parameter int unsigned SEED = 1,
    parameter int          LEN  = 2**N - 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] value,
`ifdef SC_SNG_STALL_EN
    input  logic         hold,
`endif
    output logic         ready,
    output logic         bit_valid,
    output logic         x,
    output logic         done
);

    localparam int           CW     = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST  = CW'(LEN - 1);
    localparam logic [N-1:0] SEED_V = SEED[N-1:0];

    if (N < 4 || N > 16) begin : g_bad_n
        $error("sc_sng: N must be in 4..16");
    end
    if (SEED == 0 || SEED >= (2**N)) begin : g_bad_seed
        $error("sc_sng: SEED must be nonzero and fit in N bits");
    end
    if (LEN < 1 || LEN > (2**N - 1)) begin : g_bad_len
        $error("sc_sng: LEN must be in 1..2**N-1");
    end

    sng_state_t    r_state;
    logic [N-1:0]  r_value;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  w_lfsr;
    logic          w_run;
    logic          w_adv;
    logic          w_accept;

    assign w_run    = (r_state == SNG_RUN);
    assign w_accept = (r_state == SNG_IDLE) && start;
`ifdef SC_SNG_STALL_EN
    assign w_adv    = w_run && !hold;
`else
    assign w_adv    = w_run;
`endif

    sc_lfsr #(
        .N    (N),
        .SEED (SEED_V)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (w_adv),
        .load  (w_accept),
        .q     (w_lfsr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SNG_IDLE;
            r_value <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                SNG_IDLE: begin
                    if (start) begin
                        r_state <= SNG_RUN;
                        r_value <= value;
                        r_cnt   <= '0;
                    end
                end
                SNG_RUN: begin
                    if (w_adv) begin
                        if (r_cnt == LAST) begin
                            r_state <= SNG_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= SNG_IDLE;
            endcase
        end
    end

    // Outputs decode registers; under stall, hold masks the emitted bit.
    assign ready     = (r_state == SNG_IDLE);
    assign bit_valid = w_adv;
    assign x         = w_adv && (w_lfsr <= r_value);
    assign done      = w_adv && (r_cnt == LAST);

endmodule

// File: tb/tb_sc_sng.sv
// Self-checking bench for sc_sng (N=8, SEED=1, LEN=255) against a stream model.
module tb_sc_sng;

    localparam int LEN = 255;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] value = '0;
`ifdef SC_SNG_STALL_EN
    logic       hold  = 1'b0;
`endif
    logic       ready, bit_valid, x, done;

    int npass  = 0;
    int ntotal = 0;
    logic [7:0] seq [LEN];
    logic [3:0] first4;

    always #5 clk = ~clk;

    sc_sng #(
        .N    (8),
        .SEED (1),
        .LEN  (LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .value     (value),
`ifdef SC_SNG_STALL_EN
        .hold      (hold),
`endif
        .ready     (ready),
        .bit_valid (bit_valid),
        .x         (x),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one stream from the idle state and check it against the model.
    task automatic run_stream(input string tag, input logic [7:0] v, input bit held,
                              input int abort_at, input int stall_at);
        int idx, ones, dones, bad, badgate, cyc, stall_left;
        bit fin;
        idx = 0; ones = 0; dones = 0; bad = 0; badgate = 0; cyc = 0;
        stall_left = 0; fin = 0; first4 = '0;
        @(negedge clk);
        chk({tag, ".ready_before"}, 32'(ready), 32'd1);
        start = 1'b1;
        value = v;
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (held) value = 8'h10;
            else begin start = 1'b0; value = 8'($urandom); end
`ifdef SC_SNG_STALL_EN
            if (hold && bit_valid) badgate++;
`endif
            if (bit_valid) begin
                if (idx < LEN) begin
                    if (x !== (seq[idx] <= v)) bad++;
                end else bad++;
                if (idx < 4) first4[3 - idx] = x;
                ones += int'(x);
                if (done) begin
                    dones++;
                    if (idx != LEN - 1) bad++;
                end
                if (idx == abort_at) begin
                    reset = 1'b1;
                    #1;
                    chk({tag, ".rst_ready"}, 32'(ready), 32'd1);
                    chk({tag, ".rst_outs"}, {29'd0, bit_valid, x, done}, 32'd0);
                    @(negedge clk);
                    reset = 1'b0;
                    start = 1'b0;
                    fin = 1'b1;
                end
                idx++;
                if (done) begin
                    fin = 1'b1;
                    start = 1'b0;
                end
            end else if (x !== 1'b0 || done !== 1'b0) badgate++;
`ifdef SC_SNG_STALL_EN
            if (stall_left > 0) begin
                stall_left--;
                hold = (stall_left > 0);
            end else if (idx == stall_at && !fin) begin
                hold = 1'b1;
                stall_left = 11;
            end
`endif
        end
`ifdef SC_SNG_STALL_EN
        hold = 1'b0;
`endif
        chk({tag, ".finished"}, 32'(fin), 32'd1);
        if (abort_at < 0) begin
            chk({tag, ".len"}, 32'(idx), 32'(LEN));
            chk({tag, ".ones"}, 32'(ones), 32'(v));
            chk({tag, ".done_cnt"}, 32'(dones), 32'd1);
            chk({tag, ".bits"}, 32'(bad), 32'd0);
            chk({tag, ".gating"}, 32'(badgate), 32'd0);
            @(negedge clk);
            chk({tag, ".ready_after"}, {30'd0, ready, bit_valid}, 32'b10);
        end
    endtask

    initial begin
        logic [7:0] s;
        s = 8'h01;
        for (int i = 0; i < LEN; i++) begin
            seq[i] = s;
            s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
        end

        #1;
        chk("reset.ready", 32'(ready), 32'd1);
        chk("reset.outs", {29'd0, bit_valid, x, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle_reset.ready", 32'(ready), 32'd1);
        chk("idle_reset.outs", {29'd0, bit_valid, x, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_stream("v60", 8'h60, 1'b0, -1, -1);
        chk("v60.first4", 32'(first4), 32'b1011);
        run_stream("v00", 8'h00, 1'b0, -1, -1);
        run_stream("vFF", 8'hFF, 1'b0, -1, -1);
        run_stream("v80", 8'h80, 1'b0, -1, -1);
        run_stream("held_start", 8'hC3, 1'b1, -1, -1);
        run_stream("abort", 8'h5A, 1'b0, 100, -1);
        run_stream("after_abort", 8'h5A, 1'b0, -1, -1);
        for (int k = 0; k < 3; k++) begin
            run_stream("rand", 8'($urandom), 1'b0, -1, -1);
        end
`ifdef SC_SNG_STALL_EN
        run_stream("stall80", 8'h80, 1'b0, -1, 60);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
